// File: rtl/irs_block_readout_v4.sv
// IRS block readout: queues block addresses, then clears, ramps and reads each one.
// It reads every sample of every enabled channel and streams the samples out tagged with channel and sample index.
module irs_block_readout_v4 #(
    parameter int NCH      = 8,
    parameter int NSMP     = 64,
    parameter int DATW     = 12,
    parameter int ADDRW    = 9,
    parameter int CLR_CYC  = 4,
    parameter int RAMP_CYC = 16,
    parameter int SMP_WAIT = 2,
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int SMPW    = (NSMP > 1) ? $clog2(NSMP) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             rst_ack_o,
    input  logic [ADDRW-1:0] raddr_i,
    input  logic             raddr_stb_i,
    output logic             raddr_ack_o,
    input  logic [NCH-1:0]   ch_mask_i,
    output logic [ADDRW-1:0] block_addr_o,
    output logic [NCH-1:0]   block_mask_o,
    output logic             block_start_o,
    output logic [DATW-1:0]  block_dat_o,
    output logic [CHW-1:0]   block_ch_o,
    output logic [SMPW-1:0]  block_smp_o,
    output logic             block_valid_o,
    output logic             block_done_o,
    output logic [ADDRW-1:0] irs_rd_o,
    output logic             irs_rden_o,
    output logic [SMPW-1:0]  irs_smp_o,
    output logic [CHW-1:0]   irs_ch_o,
    input  logic [DATW-1:0]  irs_dat_i,
    output logic             irs_clr_o,
    output logic             irs_ramp_o,
    output logic             irs_start_o,
    output logic             irs_readout_o,
    output logic             busy_o
);

    localparam int CNTMAX = (CLR_CYC > RAMP_CYC) ? ((CLR_CYC > SMP_WAIT) ? CLR_CYC : SMP_WAIT)
                                                 : ((RAMP_CYC > SMP_WAIT) ? RAMP_CYC : SMP_WAIT);
    localparam int CNTW   = $clog2(CNTMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_CLEAR, S_RAMP, S_READ, S_FLUSH, S_DONE
    } state_t;

    state_t           r_state;
    logic [CNTW-1:0]  r_cnt;
    logic [ADDRW-1:0] r_q_addr [2];
    logic             r_q_wp;
    logic             r_q_rp;
    logic [1:0]       r_q_cnt;
    logic             r_rst_q;
    logic             r_cap_vld;
    logic [DATW-1:0]  r_cap_dat;
    logic [CHW-1:0]   r_cap_ch;
    logic [SMPW-1:0]  r_cap_smp;

    logic             w_push;
    logic             w_pop;
    logic [CHW-1:0]   w_first_ch;
    logic [CHW-1:0]   w_nxt_ch;
    logic             w_nxt_found;

    assign w_push = raddr_stb_i && (r_q_cnt != 2'd2) && !raddr_ack_o;
    assign w_pop  = (r_state == S_IDLE) && (r_q_cnt != 2'd0);
    assign busy_o = (r_state != S_IDLE) || (r_q_cnt != 2'd0);

    // Descending scan so the lowest qualifying channel wins.
    always_comb begin
        w_first_ch  = '0;
        w_nxt_ch    = '0;
        w_nxt_found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (block_mask_o[i]) begin
                w_first_ch = CHW'(i);
                if (i > int'(irs_ch_o)) begin
                    w_nxt_ch    = CHW'(i);
                    w_nxt_found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        r_rst_q   <= rst_i;
        rst_ack_o <= rst_i & r_rst_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_q_wp      <= 1'b0;
            r_q_rp      <= 1'b0;
            r_q_cnt     <= 2'd0;
            raddr_ack_o <= 1'b0;
        end else begin
            raddr_ack_o <= w_push;
            if (w_push) begin
                r_q_addr[r_q_wp] <= raddr_i;
                r_q_wp           <= ~r_q_wp;
            end
            if (w_pop)
                r_q_rp <= ~r_q_rp;
            case ({w_push, w_pop})
                2'b10:   r_q_cnt <= r_q_cnt + 2'd1;
                2'b01:   r_q_cnt <= r_q_cnt - 2'd1;
                default: r_q_cnt <= r_q_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_cap_vld     <= 1'b0;
            r_cap_dat     <= '0;
            r_cap_ch      <= '0;
            r_cap_smp     <= '0;
            block_addr_o  <= '0;
            block_mask_o  <= '0;
            block_start_o <= 1'b0;
            block_dat_o   <= '0;
            block_ch_o    <= '0;
            block_smp_o   <= '0;
            block_valid_o <= 1'b0;
            block_done_o  <= 1'b0;
            irs_rd_o      <= '0;
            irs_rden_o    <= 1'b0;
            irs_smp_o     <= '0;
            irs_ch_o      <= '0;
            irs_clr_o     <= 1'b0;
            irs_ramp_o    <= 1'b0;
            irs_start_o   <= 1'b0;
            irs_readout_o <= 1'b0;
        end else begin
            block_start_o <= 1'b0;
            block_done_o  <= 1'b0;
            r_cap_vld     <= 1'b0;
            block_valid_o <= r_cap_vld;
            if (r_cap_vld) begin
                block_dat_o <= r_cap_dat;
                block_ch_o  <= r_cap_ch;
                block_smp_o <= r_cap_smp;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state       <= S_START;
                        block_start_o <= 1'b1;
                        block_addr_o  <= r_q_addr[r_q_rp];
                        irs_rd_o      <= r_q_addr[r_q_rp];
                        block_mask_o  <= ch_mask_i;
                        irs_rden_o    <= |ch_mask_i;
                        irs_readout_o <= 1'b1;
                    end
                end
                S_START: begin
                    r_cnt <= '0;
                    if (block_mask_o == '0) begin
                        r_state      <= S_DONE;
                        block_done_o <= 1'b1;
                    end else begin
                        r_state   <= S_CLEAR;
                        irs_clr_o <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNTW'(CLR_CYC - 1)) begin
                        r_cnt       <= '0;
                        irs_clr_o   <= 1'b0;
                        irs_ramp_o  <= 1'b1;
                        irs_start_o <= 1'b1;
                        r_state     <= S_RAMP;
                    end
                end
                S_RAMP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNTW'(RAMP_CYC - 1)) begin
                        r_cnt       <= '0;
                        irs_ramp_o  <= 1'b0;
                        irs_start_o <= 1'b0;
                        irs_ch_o    <= w_first_ch;
                        irs_smp_o   <= '0;
                        r_state     <= S_READ;
                    end
                end
                S_READ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNTW'(SMP_WAIT - 1)) begin
                        r_cnt     <= '0;
                        r_cap_vld <= 1'b1;
                        r_cap_dat <= irs_dat_i;
                        r_cap_ch  <= irs_ch_o;
                        r_cap_smp <= irs_smp_o;
                        if (irs_smp_o == SMPW'(NSMP - 1)) begin
                            irs_smp_o <= '0;
                            if (w_nxt_found)
                                irs_ch_o <= w_nxt_ch;
                            else
                                r_state <= S_FLUSH;
                        end else begin
                            irs_smp_o <= irs_smp_o + 1'b1;
                        end
                    end
                end
                // Two cycles let the last capture reach block_valid_o before done.
                S_FLUSH: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNTW'(1)) begin
                        r_cnt        <= '0;
                        block_done_o <= 1'b1;
                        irs_rden_o   <= 1'b0;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    irs_readout_o <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
